// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared defaults and FSM state type for the adder arbiter
package adder_arbiter_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int DATA_W_DEF = 32;
    localparam int ADDER_LAT_DEF = 1;
    localparam int ID_W_DEF = $clog2(N_REQ_DEF);
    typedef enum logic [1:0] {WARM, IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: requester, adder and result signals of the adder arbiter
// slave = arbiter side: takes requests/operands/add_sum/res_ready, drives grants/adder operands/result/busy
// master = environment side (requesters, adder, result consumer)
interface adder_arbiter_if import adder_arbiter_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int ID_W = $clog2(N_REQ);
    logic [N_REQ-1:0] chan_en;
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ*DATA_W-1:0] req_i;
    logic [N_REQ*DATA_W-1:0] req_q;
    logic [N_REQ-1:0] req_ready;
    logic [DATA_W-1:0] add_i;
    logic [DATA_W-1:0] add_q;
    logic [DATA_W-1:0] add_sum;
    logic res_valid;
    logic res_ready;
    logic [DATA_W-1:0] res_sum;
    logic [ID_W-1:0] res_id;
    logic busy;
    modport slave (
        input chan_en, req_valid, req_i, req_q, add_sum, res_ready,
        output req_ready, add_i, add_q, res_valid, res_sum, res_id, busy
    );
    modport master (
        output chan_en, req_valid, req_i, req_q, add_sum, res_ready,
        input req_ready, add_i, add_q, res_valid, res_sum, res_id, busy
    );
endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// adder_arbiter_rr_arbiter: combinational round-robin pick of the first eligible requester from ptr upward
// elig: eligible mask; ptr: highest-priority index; grant: one-hot winner; idx: winner index; any: elig nonzero
module adder_arbiter_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0] sum;
    // rotate so ptr lands at bit 0; the lowest set bit is then the offset from ptr
    assign rot = N_REQ'({elig, elig} >> ptr);
    always_comb begin
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) off = ID_W'(k);
    end
    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = sum >= (ID_W + 1)'(N_REQ) ? ID_W'(sum - (ID_W + 1)'(N_REQ)) : sum[ID_W-1:0];
    assign any = |elig;
    assign grant = any ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one registered I/Q averaging adder among N_REQ requesters
// M100CLK: clock; reset: sync active-high; bus: requests/grants, adder operands/sum, tagged result, busy
module adder_arbiter import adder_arbiter_pkg::*; #(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDER_LAT = ADDER_LAT_DEF
) (
    input logic M100CLK,
    input logic reset,
    adder_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ADDER_LAT + 1);
    state_t state, state_nx;
    logic [ID_W-1:0] rr_ptr, win_idx;
    logic [N_REQ-1:0] elig, win_grant;
    logic any, grant;
    logic [CNT_W-1:0] wait_cnt;
    assign elig = bus.req_valid & bus.chan_en;
    adder_arbiter_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
        .elig(elig),
        .ptr(rr_ptr),
        .grant(win_grant),
        .idx(win_idx),
        .any(any)
    );
    assign grant = state == IDLE && any;
    assign bus.req_ready = grant ? win_grant : '0;
    assign bus.busy = state != IDLE;
    always_comb begin
        state_nx = IDLE;
        state_nx = state == WARM ? IDLE :
                   state == IDLE ? (any ? WAIT : IDLE) :
                   state == WAIT ? (wait_cnt == '0 ? DONE : WAIT) :
                   state == DONE ? (bus.res_ready ? IDLE : DONE) : IDLE;
    end
    always_ff @(posedge M100CLK) begin
        if (reset) begin
            state <= WARM;
            rr_ptr <= '0;
            wait_cnt <= '0;
            bus.add_i <= '0;
            bus.add_q <= '0;
            bus.res_valid <= 1'b0;
            bus.res_sum <= '0;
            bus.res_id <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                bus.add_i <= bus.req_i[win_idx*DATA_W +: DATA_W];
                bus.add_q <= bus.req_q[win_idx*DATA_W +: DATA_W];
                bus.res_id <= win_idx;
                rr_ptr <= win_idx == ID_W'(N_REQ - 1) ? '0 : win_idx + 1'b1;
                wait_cnt <= CNT_W'(ADDER_LAT);
            end
            if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            if (state == WAIT && wait_cnt == '0) begin
                bus.res_sum <= bus.add_sum;
                bus.res_valid <= 1'b1;
            end
            if (state == DONE && bus.res_ready) bus.res_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: self-checking bench with vector table, round-robin streams, random transactions and reset abort
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;
    localparam int N = 4;
    localparam int DW = 32;
    typedef struct {
        logic [3:0] en;
        logic [3:0] valid;
        logic [31:0] i;
        logic [31:0] q;
        int exp_id;
        logic [31:0] exp_sum;
        int stall;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int model_ptr = 0;
    vec_t tbl [7];
    logic signed [DW:0] wide;
    always #5 clk = ~clk;
    adder_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();
    adder_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDER_LAT(1)) dut (
        .M100CLK(clk),
        .reset(rst),
        .bus(bus)
    );
    // registered averaging adder, one cycle latency
    assign wide = ($signed({bus.add_i[DW-1], bus.add_i}) + $signed({bus.add_q[DW-1], bus.add_q})) >>> 1;
    always @(posedge clk) bus.add_sum <= rst ? '0 : wide[DW-1:0];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic int pick(input logic [3:0] elig, input int ptr);
        for (int o = 0; o < N; o++)
            if (elig[(ptr + o) % N]) return (ptr + o) % N;
        return -1;
    endfunction
    function automatic logic [31:0] avg(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        return 32'(s >>> 1);
    endfunction
    task automatic do_txn(input logic [3:0] en, input logic [3:0] valid, input logic [127:0] ri,
                          input logic [127:0] rq, input int exp_id, input logic [31:0] exp_sum,
                          input int stall, input string tag);
        int n, lat;
        bus.chan_en = en;
        bus.req_valid = valid;
        bus.req_i = ri;
        bus.req_q = rq;
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_grant"}, 64'(bus.req_ready), 64'(4'b1 << exp_id));
        model_ptr = (exp_id + 1) % N;
        @(negedge clk); #1;
        lat = 1;
        chk({tag, "_ready_pulse"}, 64'(bus.req_ready), 0);
        while (!bus.res_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 3);
        chk({tag, "_sum"}, 64'(bus.res_sum), 64'(exp_sum));
        chk({tag, "_id"}, 64'(bus.res_id), 64'(exp_id));
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_stall_ready"}, 64'(bus.req_ready), 0);
            chk({tag, "_stall_hold"}, {bus.res_valid, bus.res_id, bus.res_sum}, {1'b1, 2'(exp_id), exp_sum});
            @(negedge clk); #1;
        end
        bus.res_ready = 1'b1;
        @(negedge clk); #1;
        bus.res_ready = 1'b0;
        chk({tag, "_accept"}, {bus.res_valid, bus.busy}, 0);
    endtask
    task automatic run_stream(input logic [3:0] en, input logic [5:0][1:0] exp, input string tag);
        int ids[$];
        int last, n;
        bus.chan_en = en;
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        #1;
        chk({tag, "_warm"}, {bus.req_ready, bus.busy}, 5'b00001);
        last = -1;
        for (int cyc = 0; cyc < 26; cyc++) begin
            if (bus.req_ready != '0) begin
                for (int k = 0; k < N; k++) if (bus.req_ready[k]) ids.push_back(k);
                if (last >= 0) chk({tag, "_gap"}, 64'(cyc - last), 4);
                last = cyc;
            end
            @(negedge clk); #1;
        end
        chk({tag, "_count"}, 64'(ids.size()), 7);
        for (int k = 0; k < 6; k++)
            chk({tag, "_order"}, 64'(k < ids.size() ? ids[k] : -1), 64'(exp[k]));
        bus.req_valid = '0;
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_drain"}, 64'(bus.busy), 0);
        bus.res_ready = 1'b0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [3:0] en, valid;
        logic [127:0] ri, rq;
        int w;
        tbl[0] = '{4'hF, 4'b0100, 32'd100, 32'd50, 2, 32'd75, 0};
        tbl[1] = '{4'hF, 4'b1111, -32'sd7, 32'd2, 3, -32'sd3, 10};
        tbl[2] = '{4'hF, 4'b1111, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0};
        tbl[3] = '{4'b1011, 4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 2};
        tbl[4] = '{4'b1011, 4'b0111, 32'h80000000, 32'h80000000, 0, 32'h80000000, 0};
        tbl[5] = '{4'hF, 4'b0001, 32'd3, 32'd0, 0, 32'd1, 1};
        tbl[6] = '{4'hF, 4'b1000, 32'hFFFFFFFF, 32'd0, 3, 32'hFFFFFFFF, 0};
        bus.chan_en = '1;
        bus.req_valid = '1;
        bus.req_i = {4{32'd5}};
        bus.req_q = {4{32'd9}};
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 0);
        chk("reset_add", {bus.add_i, bus.add_q}, 0);
        chk("reset_res", {bus.res_valid, bus.res_id, bus.res_sum}, 0);
        chk("reset_busy", 64'(bus.busy), 1);
        rst = 1'b0;
        run_stream(4'hF, {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}, "rr_all");
        do_reset();
        run_stream(4'b1011, {2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0}, "rr_mask");
        do_reset();
        for (int t = 0; t < 7; t++)
            do_txn(tbl[t].en, tbl[t].valid, {4{tbl[t].i}}, {4{tbl[t].q}},
                   tbl[t].exp_id, tbl[t].exp_sum, tbl[t].stall, $sformatf("vec%0d", t));
        for (int t = 0; t < 60; t++) begin
            en = 4'($urandom);
            valid = 4'($urandom);
            for (int k = 0; k < N; k++) begin
                ri[k*32 +: 32] = $urandom;
                rq[k*32 +: 32] = $urandom;
            end
            if ((en & valid) == '0) begin
                bus.chan_en = en;
                bus.req_valid = valid;
                bus.req_i = ri;
                bus.req_q = rq;
                #1;
                chk("rand_no_grant", {bus.req_ready, bus.busy}, 0);
                @(negedge clk); #1;
            end else begin
                w = pick(en & valid, model_ptr);
                do_txn(en, valid, ri, rq, w, avg(ri[w*32 +: 32], rq[w*32 +: 32]),
                       $urandom_range(0, 3), "rand");
            end
        end
        bus.chan_en = 4'hF;
        bus.req_valid = 4'b0010;
        bus.req_i = {32'd0, 32'd0, 32'd1000, 32'd0};
        bus.req_q = {32'd0, 32'd0, -32'sd400, 32'd0};
        #1;
        chk("abort_grant", 64'(bus.req_ready), 64'(4'b0010));
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_in_reset", {bus.res_valid, bus.req_ready, bus.busy}, 6'b000001);
        @(negedge clk); #1;
        chk("abort_no_result", 64'(bus.res_valid), 0);
        rst = 1'b0;
        model_ptr = 0;
        #1;
        chk("abort_warm", {bus.req_ready, bus.busy}, 5'b00001);
        do_txn(4'hF, 4'b0010, bus.req_i, bus.req_q, 1, 32'd300, 0, "post_rst");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
